pts_tx_ctrl: RTL and testbench

Sequencing controller for the single-data-line serial transmitter. It latches a 16-bit word, generates SCL, frames the transfer with START/STOP conditions, and steps the parallel-to-serial mux (enable plus bit index) MSB-first. After each byte it releases the line for an acknowledge bit and samples it. It sits between the host-side command logic and the PTS mux / SDA pad, and is the only driver of the mux select lines.

---
 rtl/pts_tx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pts_tx_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pts_tx_ctrl.sv
// pts_tx_ctrl
// Sequencing controller for the single-data-line serial transmitter.
// Latches a 16-bit word, generates SCL, frames the transfer with START/STOP,
// steps the parallel-to-serial mux MSB-first (pts_en + index) and samples an
// acknowledge bit after each byte.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   transfer request, accepted only while idle
//   data_in  in   16-bit word, sampled on the accept cycle
//   sda_in   in   SDA pad input, sampled for ACK
//   word_q   out  latched word, feeds the PTS mux data input
//   pts_en   out  PTS mux enable, high only while shifting data bits
//   index    out  PTS mux bit select (upper 4 bits always 0)
//   sda_oe   out  controller pulls SDA low when high (START/STOP)
//   scl      out  serial clock
//   busy     out  transfer in progress
//   done     out  one-cycle pulse at transfer end
//   ack_err  out  NACK seen in the last transfer
module pts_tx_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic        sda_in,
  output logic [15:0] word_q,
  output logic        pts_en,
  output logic [7:0]  index,
  output logic        sda_oe,
  output logic        scl,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]       state, state_nx;
  logic [1:0]       ph, ph_nx;
  logic [3:0]       bit_cnt, bit_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             accept;
  logic             nack_nx;
  logic             done_nx;

  logic             scl_nx;
  logic             oe_nx;
  logic             en_nx;
  logic [7:0]       idx_nx;

  // One tick per half-period; the divider only runs outside IDLE.
  assign tick   = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign accept = (state == ST_IDLE) && start;

  // Next-state / phase sequencing.
  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    bit_nx   = bit_cnt;
    nack_nx  = ack_err;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_START;
          ph_nx    = 2'd0;
          nack_nx  = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (ph == 2'd0) begin
            ph_nx = 2'd1;
          end else begin
            state_nx = ST_DATA;
            ph_nx    = 2'd0;
            bit_nx   = 4'd15;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (ph == 2'd0) begin
            ph_nx = 2'd1;
          end else if (bit_cnt == 4'd8 || bit_cnt == 4'd0) begin
            state_nx = ST_ACK;
            ph_nx    = 2'd0;
          end else begin
            ph_nx  = 2'd0;
            bit_nx = bit_cnt - 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          if (ph == 2'd0) begin
            ph_nx = 2'd1;
          end else if (sda_in) begin
            nack_nx  = 1'b1;
            state_nx = ST_STOP;
            ph_nx    = 2'd0;
          end else if (bit_cnt == 4'd0) begin
            state_nx = ST_STOP;
            ph_nx    = 2'd0;
          end else begin
            state_nx = ST_DATA;
            ph_nx    = 2'd0;
            bit_nx   = 4'd7;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (ph == 2'd2) begin
            state_nx = ST_IDLE;
            ph_nx    = 2'd0;
            done_nx  = 1'b1;
          end else begin
            ph_nx = ph + 2'd1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ph_nx    = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state/phase and registered, so
  // every pin changes on the same edge the phase begins.
  always_comb begin
    scl_nx = 1'b1;
    oe_nx  = 1'b0;
    en_nx  = 1'b0;
    idx_nx = index;
    case (state_nx)
      ST_START: begin
        oe_nx  = 1'b1;
        scl_nx = (ph_nx == 2'd0);
      end
      ST_DATA: begin
        en_nx  = 1'b1;
        idx_nx = {4'h0, bit_nx};
        scl_nx = ph_nx[0];
      end
      ST_ACK: begin
        scl_nx = ph_nx[0];
      end
      ST_STOP: begin
        scl_nx = (ph_nx != 2'd0);
        oe_nx  = (ph_nx != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ph      <= 2'd0;
      bit_cnt <= '0;
      div_cnt <= '0;
      word_q  <= '0;
      pts_en  <= 1'b0;
      index   <= '0;
      sda_oe  <= 1'b0;
      scl     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nx;
      ph      <= ph_nx;
      bit_cnt <= bit_nx;
      if (state == ST_IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (accept) begin
        word_q <= data_in;
      end
      pts_en  <= en_nx;
      index   <= idx_nx;
      sda_oe  <= oe_nx;
      scl     <= scl_nx;
      busy    <= (state_nx != ST_IDLE);
      done    <= done_nx;
      ack_err <= nack_nx;
    end
  end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
module tb_pts_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] data_in;
  logic        sda_in;

  logic [15:0] word_q_a, word_q_b;
  logic        pts_en_a, pts_en_b;
  logic [7:0]  index_a, index_b;
  logic        sda_oe_a, sda_oe_b;
  logic        scl_a, scl_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        ack_err_a, ack_err_b;

  always #5 clk = ~clk;

  pts_tx_ctrl #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_in), .sda_in(sda_in),
    .word_q(word_q_a), .pts_en(pts_en_a), .index(index_a), .sda_oe(sda_oe_a),
    .scl(scl_a), .busy(busy_a), .done(done_a), .ack_err(ack_err_a)
  );

  pts_tx_ctrl #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in), .sda_in(sda_in),
    .word_q(word_q_b), .pts_en(pts_en_b), .index(index_b), .sda_oe(sda_oe_b),
    .scl(scl_b), .busy(busy_b), .done(done_b), .ack_err(ack_err_b)
  );

  // sel chooses which instance is being exercised and observed.
  logic        sel;
  logic [15:0] word_q_m;
  logic        pts_en_m, sda_oe_m, scl_m, busy_m, done_m, ack_err_m;
  logic [7:0]  index_m;
  assign word_q_m  = sel ? word_q_b  : word_q_a;
  assign pts_en_m  = sel ? pts_en_b  : pts_en_a;
  assign index_m   = sel ? index_b   : index_a;
  assign sda_oe_m  = sel ? sda_oe_b  : sda_oe_a;
  assign scl_m     = sel ? scl_b     : scl_a;
  assign busy_m    = sel ? busy_b    : busy_a;
  assign done_m    = sel ? done_b    : done_a;
  assign ack_err_m = sel ? ack_err_b : ack_err_a;

  int tests  = 0;
  int failed = 0;

  // Expected line behaviour of one transfer, one entry per half-period.
  typedef struct {
    logic       scl;
    logic       oe;
    logic       en;
    logic [7:0] idx;
    logic       ack;
    logic       sda;
    logic       nack;
  } ph_t;

  ph_t        ph_q[$];
  logic [7:0] exp_idx [2];

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic build_phases(input logic [15:0] w, input logic a0, input logic a1);
    logic [7:0] last;
    logic       nack;
    ph_q.delete();
    ph_q.push_back('{1'b1, 1'b1, 1'b0, exp_idx[sel], 1'b0, 1'b0, 1'b0});
    ph_q.push_back('{1'b0, 1'b1, 1'b0, exp_idx[sel], 1'b0, 1'b0, 1'b0});
    for (int b = 15; b >= 8; b--) begin
      ph_q.push_back('{1'b0, 1'b0, 1'b1, 8'(b), 1'b0, 1'b0, 1'b0});
      ph_q.push_back('{1'b1, 1'b0, 1'b1, 8'(b), 1'b0, 1'b0, 1'b0});
    end
    ph_q.push_back('{1'b0, 1'b0, 1'b0, 8'd8, 1'b1, a0, 1'b0});
    ph_q.push_back('{1'b1, 1'b0, 1'b0, 8'd8, 1'b1, a0, 1'b0});
    last = 8'd8;
    nack = a0;
    if (!a0) begin
      for (int b = 7; b >= 0; b--) begin
        ph_q.push_back('{1'b0, 1'b0, 1'b1, 8'(b), 1'b0, 1'b0, 1'b0});
        ph_q.push_back('{1'b1, 1'b0, 1'b1, 8'(b), 1'b0, 1'b0, 1'b0});
      end
      ph_q.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, a1, 1'b0});
      ph_q.push_back('{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, a1, 1'b0});
      last = 8'd0;
      nack = a1;
    end
    ph_q.push_back('{1'b0, 1'b1, 1'b0, last, 1'b0, 1'b0, nack});
    ph_q.push_back('{1'b1, 1'b1, 1'b0, last, 1'b0, 1'b0, nack});
    ph_q.push_back('{1'b1, 1'b0, 1'b0, last, 1'b0, 1'b0, nack});
    exp_idx[sel] = last;
  endtask

  // Must be entered at a negedge with the selected instance idle (or in its
  // done cycle). Returns at the negedge of the done cycle.
  task automatic run_xfer(input string name, input logic [15:0] w, input logic a0,
                          input logic a1, input bit hold, input bit noise, input int div);
    logic [29:0] obs, exp;
    logic [15:0] ser, exp_ser;
    logic        nack_final;
    build_phases(w, a0, a1);
    nack_final = a0 ? 1'b1 : a1;
    data_in = w;
    set_start(1'b1);
    tests++;
    if (busy_m !== 1'b0) begin
      failed++;
      $display("FAIL %s accept_busy: got %b expected 0", name, busy_m);
    end
    ser = '0;
    foreach (ph_q[p]) begin
      for (int c = 0; c < div; c++) begin
        @(posedge clk); #1;
        set_start(hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0));
        data_in = noise ? 16'hFFFF : 16'($urandom);
        sda_in  = ph_q[p].ack ? ph_q[p].sda : 1'($urandom);
        @(negedge clk);
        exp = {ph_q[p].scl, ph_q[p].oe, ph_q[p].en, ph_q[p].idx, 1'b1, 1'b0, ph_q[p].nack, w};
        obs = {scl_m, sda_oe_m, pts_en_m, index_m, busy_m, done_m, ack_err_m, word_q_m};
        tests++;
        if (obs !== exp) begin
          failed++;
          $display("FAIL %s phase %0d cyc %0d {scl,oe,en,idx,busy,done,ack_err,word}: got %h expected %h",
                   name, p, c, obs, exp);
        end
        if (c == 0 && ph_q[p].en && ph_q[p].scl)
          ser = {ser[14:0], word_q_m[index_m[3:0]]};
      end
    end
    @(posedge clk); #1;
    set_start(hold);
    sda_in = 1'b1;
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, exp_idx[sel], 1'b0, 1'b1, nack_final, w};
    obs = {scl_m, sda_oe_m, pts_en_m, index_m, busy_m, done_m, ack_err_m, word_q_m};
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s done_cycle: got %h expected %h", name, obs, exp);
    end
    exp_ser = a0 ? {8'h00, w[15:8]} : w;
    tests++;
    if (ser !== exp_ser) begin
      failed++;
      $display("FAIL %s serial_bits: got %h expected %h", name, ser, exp_ser);
    end
  endtask

  task automatic test_reset;
    logic [29:0] obs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = {scl_a, sda_oe_a, pts_en_a, index_a, busy_a, done_a, ack_err_a, word_q_a};
    tests++;
    if (obs !== {1'b1, 29'h0}) begin
      failed++;
      $display("FAIL reset_div4: got %h expected %h", obs, {1'b1, 29'h0});
    end
    obs = {scl_b, sda_oe_b, pts_en_b, index_b, busy_b, done_b, ack_err_b, word_q_b};
    tests++;
    if (obs !== {1'b1, 29'h0}) begin
      failed++;
      $display("FAIL reset_div1: got %h expected %h", obs, {1'b1, 29'h0});
    end
    rst_n = 1'b1;
    exp_idx[0] = 8'd0;
    exp_idx[1] = 8'd0;
    repeat (2) @(negedge clk);
    obs = {scl_a, sda_oe_a, pts_en_a, index_a, busy_a, done_a, ack_err_a, word_q_a};
    tests++;
    if (obs !== {1'b1, 29'h0}) begin
      failed++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, {1'b1, 29'h0});
    end
  endtask

  task automatic test_full_word;
    sel = 1'b0;
    run_xfer("full_a5c3", 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    repeat (3) begin
      @(negedge clk);
      run_xfer("random_word", 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4);
    end
  endtask

  task automatic test_nack_first;
    sel = 1'b0;
    @(negedge clk);
    run_xfer("nack_first", 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    run_xfer("ack_err_clear", 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_busy_ignore;
    sel = 1'b0;
    @(negedge clk);
    run_xfer("start_while_busy", 16'h1234 ^ 16'($urandom_range(0, 255)), 1'b0, 1'b0,
             1'b0, 1'b1, 4);
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    @(negedge clk);
    run_xfer("b2b_first", 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 4);
    run_xfer("b2b_second", 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 4);
  endtask

  task automatic test_reset_mid_data;
    logic [29:0] obs;
    bit          found;
    sel = 1'b0;
    @(negedge clk);
    data_in = 16'($urandom);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pts_en_a === 1'b1 && index_a === 8'd10) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL reach_bit10: got not_found expected index 10 within 200 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {scl_a, sda_oe_a, pts_en_a, index_a, busy_a, done_a, ack_err_a, word_q_a};
    tests++;
    if (obs !== {1'b1, 29'h0}) begin
      failed++;
      $display("FAIL async_reset_mid_data: got %h expected %h", obs, {1'b1, 29'h0});
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        failed++;
        $display("FAIL no_done_in_reset: got done=%b busy=%b expected 0 0", done_a, busy_a);
      end
    end
    rst_n = 1'b1;
    exp_idx[0] = 8'd0;
    exp_idx[1] = 8'd0;
    repeat (3) begin
      @(negedge clk);
      obs = {scl_a, sda_oe_a, pts_en_a, index_a, busy_a, done_a, ack_err_a, word_q_a};
      tests++;
      if (obs !== {1'b1, 29'h0}) begin
        failed++;
        $display("FAIL idle_after_mid_reset: got %h expected %h", obs, {1'b1, 29'h0});
      end
    end
  endtask

  task automatic test_clkdiv1;
    sel = 1'b1;
    @(negedge clk);
    run_xfer("div1_0001", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_xfer("div1_b2b_nack", 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    run_xfer("div1_random", 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1);
    sel = 1'b0;
  endtask

  initial begin
    sel        = 1'b0;
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    data_in    = '0;
    sda_in     = 1'b1;
    exp_idx[0] = 8'd0;
    exp_idx[1] = 8'd0;
    test_reset;
    test_full_word;
    test_nack_first;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_data;
    test_clkdiv1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
